// File: rtl/vm_pkg.sv
// ---------------------------------------------------------------------------
// vm_pkg
//
// Definitions shared by the vending-machine blocks (the coin acceptor and
// the change dispenser):
//   - 2-bit coin codes on the coin bus and their face values
//   - state encoding of the change dispenser FSM
//   - default amount width
//   - pick_coin: the greedy denomination choice (10, then 5, then 1)
//
// pick_coin takes its operands at a fixed PICK_W width so that callers with
// different AMT_W / INV_W settings can zero-extend into it.
// ---------------------------------------------------------------------------
package vm_pkg;

   localparam int AMT_W  = 5;
   localparam int PICK_W = 16;

   // Coin bus encoding
   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_1    = 2'b01;
   localparam logic [1:0] COIN_5    = 2'b10;
   localparam logic [1:0] COIN_10   = 2'b11;

   // Face values
   localparam int VAL_1  = 1;
   localparam int VAL_5  = 5;
   localparam int VAL_10 = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_PULSE  = 2'd2,
      ST_GAP    = 2'd3
   } disp_state_t;

   typedef struct packed {
      logic [1:0] code;   // COIN_NONE when nothing fits
      logic [4:0] value;  // face value of code, 0 for COIN_NONE
   } coin_pick_t;

   // Greedy choice. A coin is only offered when the amount still owed is at
   // least its value and there is stock of it, so the caller can subtract
   // without any risk of wrap-around.
   function automatic coin_pick_t pick_coin(
      input logic [PICK_W-1:0] remaining,
      input logic [PICK_W-1:0] inv_1,
      input logic [PICK_W-1:0] inv_5,
      input logic [PICK_W-1:0] inv_10
   );
      coin_pick_t p;
      p.code  = COIN_NONE;
      p.value = '0;
      if ((remaining >= PICK_W'(VAL_10)) && (inv_10 != '0)) begin
         p.code  = COIN_10;
         p.value = 5'(VAL_10);
      end else if ((remaining >= PICK_W'(VAL_5)) && (inv_5 != '0)) begin
         p.code  = COIN_5;
         p.value = 5'(VAL_5);
      end else if ((remaining >= PICK_W'(VAL_1)) && (inv_1 != '0)) begin
         p.code  = COIN_1;
         p.value = 5'(VAL_1);
      end
      return p;
   endfunction

endpackage

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
//
// Pays out change one coin at a time on a 2-bit coin bus, choosing coins
// greedily (10, 5, 1) against per-denomination inventory counters. Each
// coin code is held for PULSE_CYCLES cycles and followed by at least
// GAP_CYCLES+1 cycles of 00 so an edge-detecting coin counter downstream
// sees every coin exactly once.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high; aborts any dispense in progress
//   start      one-cycle request, sampled only while idle
//   amount     change to return, captured with start
//   refill     reload all inventories to INV_INIT, honoured only while idle
//              and only when start is low
//   coin_out   coin code being dispensed (00 = none)
//   busy       dispense in progress
//   done       one-cycle completion pulse (busy already low)
//   short      valid with done, held until next start: change not covered
//   remaining  amount still owed; the shortfall after a short completion
//   inv_1/5/10 current inventory of each denomination
// ---------------------------------------------------------------------------
module change_dispenser #(
   parameter int AMT_W        = vm_pkg::AMT_W,
   parameter int INV_W        = 4,
   parameter int INV_INIT     = 8,
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   input  logic             refill,
   output logic [1:0]       coin_out,
   output logic             busy,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] remaining,
   output logic [INV_W-1:0] inv_1,
   output logic [INV_W-1:0] inv_5,
   output logic [INV_W-1:0] inv_10
);

   import vm_pkg::PICK_W;
   import vm_pkg::COIN_NONE;
   import vm_pkg::disp_state_t;
   import vm_pkg::ST_IDLE;
   import vm_pkg::ST_SELECT;
   import vm_pkg::ST_PULSE;
   import vm_pkg::ST_GAP;
   import vm_pkg::coin_pick_t;
   import vm_pkg::pick_coin;

   // Phase counter only has to reach the longer of the two hold times.
   localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [INV_W-1:0] INV_LOAD  = INV_W'(INV_INIT);
   localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_CYCLES - 1);

   disp_state_t      state_reg;
   logic [1:0]       coin_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             short_reg;
   logic [AMT_W-1:0] remaining_reg;
   logic [CNT_W-1:0] cnt_reg;

   // Inventory indexed by coin code: [1] = 1, [2] = 5, [3] = 10.
   logic [INV_W-1:0] inv_reg [1:3];

   coin_pick_t       pick;

   // Greedy choice is combinational from the registered state; it is only
   // acted on in SELECT.
   assign pick = pick_coin(PICK_W'(remaining_reg),
                           PICK_W'(inv_reg[1]),
                           PICK_W'(inv_reg[2]),
                           PICK_W'(inv_reg[3]));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         coin_reg      <= COIN_NONE;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         short_reg     <= 1'b0;
         remaining_reg <= '0;
         cnt_reg       <= '0;
         for (int i = 1; i <= 3; i++) begin
            inv_reg[i] <= INV_LOAD;
         end
      end else begin
         done_reg <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               // start has priority; a refill in the same cycle is lost.
               if (start) begin
                  remaining_reg <= amount;
                  short_reg     <= 1'b0;
                  busy_reg      <= 1'b1;
                  state_reg     <= ST_SELECT;
               end else if (refill) begin
                  for (int i = 1; i <= 3; i++) begin
                     inv_reg[i] <= INV_LOAD;
                  end
               end
            end

            ST_SELECT: begin
               if (pick.code != COIN_NONE) begin
                  coin_reg      <= pick.code;
                  remaining_reg <= remaining_reg - AMT_W'(pick.value);
                  for (int i = 1; i <= 3; i++) begin
                     if (pick.code == 2'(i)) begin
                        inv_reg[i] <= inv_reg[i] - INV_W'(1);
                     end
                  end
                  cnt_reg   <= '0;
                  state_reg <= ST_PULSE;
               end else begin
                  // Nothing fits: either paid in full or out of suitable
                  // coins, in which case remaining keeps the shortfall.
                  done_reg  <= 1'b1;
                  short_reg <= (remaining_reg != '0);
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end

            ST_PULSE: begin
               if (cnt_reg == PULSE_END) begin
                  coin_reg  <= COIN_NONE;
                  cnt_reg   <= '0;
                  state_reg <= ST_GAP;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end

            ST_GAP: begin
               if (cnt_reg == GAP_END) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_SELECT;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end

            default: begin
               coin_reg  <= COIN_NONE;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign coin_out  = coin_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign short     = short_reg;
   assign remaining = remaining_reg;
   assign inv_1     = inv_reg[1];
   assign inv_5     = inv_reg[2];
   assign inv_10    = inv_reg[3];

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Returns change to the customer by emitting coins one at a time on a 2-bit coin bus.
- Uses the same encoding as the coin acceptor: 00 none, 01 = 1₫, 10 = 5₫, 11 = 10₫.
- Selection is greedy (10, then 5, then 1) against per-denomination inventory counters.
- Sits after the vending FSM; its coin_out is shaped (held pulse, then forced 00 gap) so an edge-detecting coin counter counts each coin exactly once.

Parameters:
- AMT_W, 5, width of amount / remaining.
- INV_W, 4, width of each inventory counter.
- INV_INIT, 8, coins of each denomination loaded at reset and on refill.
- PULSE_CYCLES, 2, cycles each coin code is held on coin_out (≥1).
- GAP_CYCLES, 2, cycles of 00 after each pulse before the next select (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- amount  in  AMT_W  change to return; captured with start
- refill  in  1  reload all inventories to INV_INIT; honoured only in IDLE
- coin_out  out  2  coin code being dispensed
- busy  out  1  dispense in progress
- done  out  1  one-cycle completion pulse
- short  out  1  valid with done and held until next start: 1 = inventory could not cover remaining
- remaining  out  AMT_W  amount still owed; shortfall after a short completion
- inv_1, inv_5, inv_10  out  INV_W each  current inventory

Behaviour:
- Reset (synchronous): state IDLE; coin_out=00; busy=0; done=0; short=0; remaining=0; all inventories=INV_INIT. Reset mid-dispense aborts immediately (coin_out=00 next cycle) and restores inventories (in-flight dispense is forgotten).
- States: IDLE, SELECT, PULSE, GAP.
- IDLE
  - start=1: remaining<=amount, short<=0, busy<=1, go SELECT.
  - refill=1 (without start): inventories<=INV_INIT.
  - start and refill in the same cycle: start wins, refill dropped.
- SELECT (coin_out=00). Evaluated in priority order:
  - remaining≥10 and inv_10>0: code 11, subtract 10.
  - remaining≥5 and inv_5>0: code 10, subtract 5.
  - remaining≥1 and inv_1>0: code 01, subtract 1.
  - On a coin: register coin_out<=code, decrement remaining and the chosen inventory in the same edge, go PULSE.
  - remaining==0: done<=1, short<=0, busy<=0, go IDLE.
  - remaining>0 but no coin fits: done<=1, short<=1, busy<=0, go IDLE; remaining holds the shortfall.
- PULSE: coin_out held for exactly PULSE_CYCLES cycles, then coin_out<=00, go GAP.
- GAP: GAP_CYCLES cycles of 00, then SELECT. Minimum low time between coins is GAP_CYCLES+1 cycles (includes SELECT).
- Coin period is PULSE_CYCLES+GAP_CYCLES+1 cycles.
- done is high for one cycle only, the cycle after the final SELECT; busy is already 0 in that cycle.
- start and refill while busy are ignored, with no queuing.
- Arithmetic: subtraction happens only after the ≥ check, so remaining never wraps. Inventories never decrement below 0. amount=0 completes with no coins.

Decomposition:
- Shared package vm_pkg holds:
  - coin codes COIN_NONE/COIN_1/COIN_5/COIN_10 (2'b00..2'b11);
  - coin values 1/5/10;
  - state enum for this block;
  - AMT_W.
- The coin acceptor (money counter) imports the same codes.
- Greedy choice lives in a combinational function pick_coin in vm_pkg, taking remaining and the three inventories and returning code and value. No separate sub-module is needed.

Test Plan (defaults; start at cycle 0):
- Reset, then amount=17, full inventory -> SELECT cycles 1/6/11/16/21; coin_out=11 @2-3, 10 @7-8, 01 @12-13, 01 @17-18; done @22, short=0, remaining=0; inv_10=7, inv_5=7, inv_1=6.
- amount=0 -> no coins; done @2, busy low @2, short=0.
- Refill in IDLE, then inv_10=0 and inv_5=0 forced by prior dispenses, inv_1=2, amount=7 -> two 01 coins @2-3 and @7-8; done @12, short=1, remaining=5, inv_1=0.
- start with amount=9 pulsed again at cycle 3 with amount=20, plus refill at cycle 4 -> second start and refill ignored; coins 10, 01×4; inventories unchanged by refill.
- Reset asserted at cycle 2 during the first PULSE of amount=10 -> coin_out=00, busy=0 @3; inventories=8; no done.
- Feed coin_out into the money counter for amount=31, full inventory -> counter total reaches 31 exactly (each coin counted once); done with short=0.
